// File: rtl/buf_gather_if.sv
// rtl/buf_gather_if.sv - lane write and row drain signals of the ping-pong gather buffer
interface buf_gather_if #(
    parameter int DATALEN = 16,
    parameter int FFTCHNL = 8,
    parameter int REPLICA = 8,
    parameter int INDXLEN = 6
);
    localparam int EW = 2 * DATALEN;
    localparam int RW = 2 * FFTCHNL;

    logic [REPLICA-1:0]         invalid;
    logic [REPLICA*INDXLEN-1:0] inaddr;
    logic [REPLICA*EW-1:0]      indata;
    logic                       inlast;
    logic                       inready;
    logic                       outvalid;
    logic                       outready;
    logic [RW*EW-1:0]           outdata;
    logic                       outlast;
    logic                       err_collide;
    logic                       err_overflow;

    modport master (
        output invalid, inaddr, indata, inlast, outready,
        input  inready, outvalid, outdata, outlast, err_collide, err_overflow
    );

    modport slave (
        input  invalid, inaddr, indata, inlast, outready,
        output inready, outvalid, outdata, outlast, err_collide, err_overflow
    );
endinterface

// File: rtl/buf_gather.sv
// rtl/buf_gather.sv - ping-pong frame buffer: random-address lane writes, sequential row drain
// Frames fill and drain in the same bank order, so fill_sel and drain_sel each just toggle.
module buf_gather #(
    parameter int DATALEN = 16,
    parameter int FFTCHNL = 8,
    parameter int REPLICA = 8,
    parameter int INDXLEN = 6
) (
    input  logic         clk,
    input  logic         rst,
    buf_gather_if.slave  bus
);
    localparam int EW    = 2 * DATALEN;
    localparam int RW    = 2 * FFTCHNL;
    localparam int DEPTH = 2 ** INDXLEN;
    localparam int CW    = $clog2(RW);
    localparam int ROWW  = INDXLEN - CW;
    localparam int ROWS  = DEPTH / RW;

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_e;

    bank_state_e      state_q [2];
    bank_state_e      state_d [2];
    logic             fill_sel_q, fill_sel_d;
    logic             drain_sel_q, drain_sel_d;
    logic [ROWW-1:0]  row_q, row_d;
    logic             outvalid_q, outvalid_d;
    logic             outlast_q, outlast_d;
    logic [RW*EW-1:0] outdata_q, outdata_d;
    logic             err_collide_q, err_collide_d;
    logic             err_overflow_q, err_overflow_d;

    logic [EW-1:0]    bank_mem [2][DEPTH];

    logic             inready, in_any, accept, collide;
    logic             fire, last_fire, load_new, new_bank, ld_bank;
    logic [ROWW-1:0]  ld_row;
    logic [RW*EW-1:0] row_data;

    assign inready = (state_q[fill_sel_q] == B_EMPTY) || (state_q[fill_sel_q] == B_FILLING);
    assign in_any  = (|bus.invalid) | bus.inlast;
    assign accept  = in_any & inready;

    assign bus.inready      = inready;
    assign bus.outvalid     = outvalid_q;
    assign bus.outlast      = outlast_q;
    assign bus.outdata      = outdata_q;
    assign bus.err_collide  = err_collide_q;
    assign bus.err_overflow = err_overflow_q;

    always_comb begin
        collide = 1'b0;
        for (int r = 0; r < REPLICA; r++) begin
            for (int s = r + 1; s < REPLICA; s++) begin
                if (bus.invalid[r] && bus.invalid[s] &&
                    bus.inaddr[r*INDXLEN +: INDXLEN] == bus.inaddr[s*INDXLEN +: INDXLEN])
                    collide = 1'b1;
            end
        end
    end

    always_comb begin
        row_data = '0;
        for (int c = 0; c < RW; c++)
            row_data[c*EW +: EW] = bank_mem[ld_bank][{ld_row, CW'(c)}];
    end

    always_comb begin
        state_d        = state_q;
        fill_sel_d     = fill_sel_q;
        drain_sel_d    = drain_sel_q;
        row_d          = row_q;
        outvalid_d     = outvalid_q;
        outlast_d      = outlast_q;
        outdata_d      = outdata_q;
        err_collide_d  = err_collide_q | (collide & inready);
        err_overflow_d = err_overflow_q | (in_any & ~inready);

        fire      = outvalid_q & bus.outready;
        last_fire = fire & outlast_q;
        // The engine may pick up the next FULL bank on the same edge the last row leaves.
        new_bank  = last_fire ? ~drain_sel_q : drain_sel_q;
        load_new  = (~outvalid_q | last_fire) & (state_q[new_bank] == B_FULL);
        ld_bank   = load_new ? new_bank : drain_sel_q;
        ld_row    = load_new ? '0 : row_q + 1'b1;

        if (accept) begin
            if (bus.inlast) begin
                state_d[fill_sel_q] = B_FULL;
                fill_sel_d          = ~fill_sel_q;
            end else begin
                state_d[fill_sel_q] = B_FILLING;
            end
        end

        if (last_fire) begin
            state_d[drain_sel_q] = B_EMPTY;
            drain_sel_d          = ~drain_sel_q;
            outvalid_d           = 1'b0;
            outlast_d            = 1'b0;
        end

        if (load_new) begin
            state_d[new_bank] = B_DRAINING;
            outvalid_d        = 1'b1;
            row_d             = ld_row;
            outdata_d         = row_data;
            outlast_d         = (ld_row == ROWW'(ROWS - 1));
        end else if (fire && !outlast_q) begin
            row_d     = ld_row;
            outdata_d = row_data;
            outlast_d = (ld_row == ROWW'(ROWS - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0]     <= B_EMPTY;
            state_q[1]     <= B_EMPTY;
            fill_sel_q     <= 1'b0;
            drain_sel_q    <= 1'b0;
            row_q          <= '0;
            outvalid_q     <= 1'b0;
            outlast_q      <= 1'b0;
            outdata_q      <= '0;
            err_collide_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_sel_q     <= fill_sel_d;
            drain_sel_q    <= drain_sel_d;
            row_q          <= row_d;
            outvalid_q     <= outvalid_d;
            outlast_q      <= outlast_d;
            outdata_q      <= outdata_d;
            err_collide_q  <= err_collide_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Later lanes overwrite earlier ones, so the highest colliding lane wins.
    always_ff @(posedge clk) begin
        for (int r = 0; r < REPLICA; r++) begin
            if (bus.invalid[r] && inready)
                bank_mem[fill_sel_q][bus.inaddr[r*INDXLEN +: INDXLEN]] <= bus.indata[r*EW +: EW];
        end
    end
endmodule

// File: tb/tb_buf_gather.sv
// tb/tb_buf_gather.sv - scoreboard bench for buf_gather
module tb_buf_gather;
    localparam int DATALEN = 16;
    localparam int FFTCHNL = 8;
    localparam int REPLICA = 8;
    localparam int INDXLEN = 6;
    localparam int EW      = 2 * DATALEN;
    localparam int RW      = 2 * FFTCHNL;
    localparam int OW      = RW * EW;
    localparam int ROWS    = (2 ** INDXLEN) / RW;

    typedef struct {
        logic [OW-1:0] data;
        logic [OW-1:0] mask;
        logic          last;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buf_gather_if #(.DATALEN(DATALEN), .FFTCHNL(FFTCHNL), .REPLICA(REPLICA), .INDXLEN(INDXLEN)) bus ();

    buf_gather #(.DATALEN(DATALEN), .FFTCHNL(FFTCHNL), .REPLICA(REPLICA), .INDXLEN(INDXLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    row_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        row_t e;
        if (!rst && bus.outvalid && bus.outready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL row_unexpected: got beat %0h required no beat", bus.outdata);
            end else begin
                e = exp_q.pop_front();
                if ((((bus.outdata ^ e.data) & e.mask) != '0) || (bus.outlast !== e.last)) begin
                    n_fail++;
                    $display("FAIL row: got %0h last %0b required %0h last %0b",
                             bus.outdata & e.mask, bus.outlast, e.data & e.mask, e.last);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.invalid = '0;
        bus.inaddr  = '0;
        bus.indata  = '0;
        bus.inlast  = 1'b0;
    endtask

    task automatic set_lane(input int r, input int addr, input logic [31:0] d);
        bus.invalid[r]                    = 1'b1;
        bus.inaddr[r*INDXLEN +: INDXLEN]  = INDXLEN'(addr);
        bus.indata[r*EW +: EW]            = d;
    endtask

    task automatic fill_frame(input logic [31:0] base);
        for (int cyc = 0; cyc < 8; cyc++) begin
            idle_inputs();
            for (int r = 0; r < REPLICA; r++)
                set_lane(r, cyc * 8 + r, base + 32'(cyc * 8 + r));
            bus.inlast = (cyc == 7);
            step();
        end
        idle_inputs();
    endtask

    function automatic row_t full_row(input logic [31:0] base, input int j);
        row_t t;
        t.data = '0;
        for (int c = 0; c < RW; c++)
            t.data[c*EW +: EW] = base + 32'(j * 16 + c);
        t.mask = '1;
        t.last = (j == ROWS - 1);
        return t;
    endfunction

    task automatic push_frame(input logic [31:0] base);
        for (int j = 0; j < ROWS; j++)
            exp_q.push_back(full_row(base, j));
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!bus.outvalid && n < 20) begin
            step();
            n++;
        end
        chk(name, bus.outvalid, 1'b1);
    endtask

    initial begin
        row_t r0, r3;
        idle_inputs();
        bus.outready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_inready", bus.inready, 1'b1);
        chk("reset_outvalid", bus.outvalid, 1'b0);
        chk("reset_outlast", bus.outlast, 1'b0);
        chk("reset_outdata", bus.outdata, '0);
        chk("reset_err_collide", bus.err_collide, 1'b0);
        chk("reset_err_overflow", bus.err_overflow, 1'b0);

        // reset in the middle of a drain
        fill_frame(32'h1);
        wait_valid("t1_valid");
        exp_q.push_back(full_row(32'h1, 0));
        exp_q.push_back(full_row(32'h1, 1));
        bus.outready = 1'b1;
        step();
        step();
        bus.outready = 1'b0;
        rst = 1'b1;
        #2;
        chk("t1_rst_outvalid", bus.outvalid, 1'b0);
        chk("t1_rst_inready", bus.inready, 1'b1);
        chk("t1_rst_errs", {bus.err_collide, bus.err_overflow}, 2'b00);
        chk("t1_rows_before_reset", exp_q.size(), 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();

        // basic frame, latency and row order
        push_frame(32'h1);
        bus.outready = 1'b1;
        fill_frame(32'h1);
        chk("t2_lat_k", bus.outvalid, 1'b0);
        step();
        chk("t2_lat_k1", bus.outvalid, 1'b1);
        chk("t2_row0_data", bus.outdata, full_row(32'h1, 0).data);
        for (int i = 0; i < 5; i++) step();
        chk("t2_drained", exp_q.size(), 0);

        // stall during row 2
        bus.outready = 1'b0;
        push_frame(32'h3000);
        fill_frame(32'h3000);
        wait_valid("t3_valid");
        bus.outready = 1'b1;
        step();
        step();
        bus.outready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_data", bus.outdata, full_row(32'h3000, 2).data);
            chk("t3_hold_last", bus.outlast, 1'b0);
            step();
        end
        bus.outready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t3_drained", exp_q.size(), 0);

        // both banks full, overflow, back-to-back frames
        bus.outready = 1'b0;
        push_frame(32'h4000);
        push_frame(32'h5000);
        fill_frame(32'h4000);
        wait_valid("t4_a_valid");
        fill_frame(32'h5000);
        chk("t4_inready_low", bus.inready, 1'b0);
        chk("t4_ovf_clear", bus.err_overflow, 1'b0);
        set_lane(0, 0, 32'hDEAD);
        bus.inlast = 1'b1;
        step();
        idle_inputs();
        chk("t4_ovf_set", bus.err_overflow, 1'b1);
        chk("t4_inready_still_low", bus.inready, 1'b0);
        bus.outready = 1'b1;
        for (int i = 0; i < 2 * ROWS; i++) begin
            chk("t4_no_bubble", bus.outvalid, 1'b1);
            step();
        end
        step();
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_inready_back", bus.inready, 1'b1);
        chk("t4_ovf_sticky", bus.err_overflow, 1'b1);

        // collision and inlast with same-cycle write
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t5_collide_clear", bus.err_collide, 1'b0);
        r0.data = '0; r0.mask = '0; r0.last = 1'b0;
        r0.data[7*EW +: EW] = 32'h0000_5555;
        r0.mask[7*EW +: EW] = '1;
        r3.data = '0; r3.mask = '0; r3.last = 1'b1;
        r3.data[15*EW +: EW] = 32'h0BAD_F00D;
        r3.mask[15*EW +: EW] = '1;
        exp_q.push_back(r0);
        exp_q.push_back('{data: '0, mask: '0, last: 1'b0});
        exp_q.push_back('{data: '0, mask: '0, last: 1'b0});
        exp_q.push_back(r3);
        bus.outready = 1'b1;
        set_lane(2, 7, 32'h0000_AAAA);
        set_lane(5, 7, 32'h0000_5555);
        step();
        idle_inputs();
        chk("t5_collide_set", bus.err_collide, 1'b1);
        chk("t5_no_ovf", bus.err_overflow, 1'b0);
        set_lane(0, 63, 32'h0BAD_F00D);
        bus.inlast = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 8; i++) step();
        chk("t6_drained", exp_q.size(), 0);
        chk("t5_collide_sticky", bus.err_collide, 1'b1);
        rst = 1'b1;
        #2;
        chk("t5_collide_cleared", bus.err_collide, 1'b0);
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
